// File: rtl/kbd_ps2.sv
// PS/2 keyboard receiver: pin synchroniser, 11-bit frame deframer and scancode FIFO.
// Define KBD_PARITY_EN to discard frames that fail the odd-parity check.
module kbd_ps2 #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 20000
) (
  input  logic       iClk,
  input  logic       iRst,
  input  logic       iPs2Clk,
  input  logic       iPs2Dat,
  input  logic       iAck,
  output logic       oIrq,
  output logic [7:0] oData,
  output logic       oOvf
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} stateT;

  stateT       state, stateNext;
  logic [1:0]  clkSync, datSync;
  logic        clkPrev;
  logic        fall, ps2Bit;
  logic [TW-1:0] toCnt;
  logic        timedOut;
  logic [2:0]  bitCnt;
  logic [7:0]  shiftReg;
  logic        parityOk, frameOk, pushReq;

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] rdPtr, wrPtr;
  logic [CW-1:0] count;
  logic          full, empty, pop, doWrite, setOvf;

  // NOTE: every sequential block uses non-blocking assignments so all flops update together.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      clkSync <= 2'b11;
      datSync <= 2'b11;
      clkPrev <= 1'b1;
    end else begin
      clkSync <= {clkSync[0], iPs2Clk};
      datSync <= {datSync[0], iPs2Dat};
      clkPrev <= clkSync[1];
    end
  end

  // Data needs no history flop: its second stage lines up with the clock edge detect.
  assign fall   = clkPrev & ~clkSync[1];
  assign ps2Bit = datSync[1];

  always_ff @(posedge iClk) begin
    if (iRst)                        toCnt <= '0;
    else if (fall)                   toCnt <= '0;
    else if (toCnt != TW'(TIMEOUT))  toCnt <= toCnt + TW'(1);
  end

  assign timedOut = (toCnt == TW'(TIMEOUT));

`ifdef KBD_PARITY_EN
  logic parBit;
  assign parityOk = ^{shiftReg, parBit};
`else
  assign parityOk = 1'b1;
`endif

  assign frameOk = ps2Bit & parityOk;

  always_ff @(posedge iClk) begin
    if (iRst) state <= IDLE;
    else      state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    pushReq   = 1'b0;
    if (fall) begin
      case (state)
        IDLE:   if (!ps2Bit) stateNext = DATA;
        DATA:   if (bitCnt == 3'd7) stateNext = PARITY;
        PARITY: stateNext = STOP;
        STOP: begin
          pushReq   = frameOk;
          stateNext = IDLE;
        end
        default: stateNext = IDLE;
      endcase
    end else if (timedOut && state != IDLE) begin
      stateNext = IDLE;
    end
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      bitCnt   <= '0;
      shiftReg <= '0;
`ifdef KBD_PARITY_EN
      parBit   <= 1'b0;
`endif
    end else if (fall) begin
      case (state)
        IDLE: bitCnt <= '0;
        DATA: begin
          shiftReg <= {ps2Bit, shiftReg[7:1]};
          bitCnt   <= bitCnt + 3'd1;
        end
`ifdef KBD_PARITY_EN
        PARITY: parBit <= ps2Bit;
`endif
        default: ;
      endcase
    end
  end

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign pop     = iAck & ~empty;
  assign doWrite = pushReq & (~full | pop);
  assign setOvf  = pushReq & full & ~pop;

  // NOTE: storage is deliberately not reset; the count masks stale entries.
  always_ff @(posedge iClk) begin
    if (!iRst && doWrite) mem[wrPtr] <= shiftReg;
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
      oOvf  <= 1'b0;
    end else begin
      if (doWrite) wrPtr <= wrPtr + PW'(1);
      if (pop)     rdPtr <= rdPtr + PW'(1);
      case ({doWrite, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
      if (setOvf)    oOvf <= 1'b1;
      else if (iAck) oOvf <= 1'b0;
    end
  end

  assign oIrq  = ~empty;
  assign oData = empty ? 8'h00 : mem[rdPtr];

endmodule

// File: tb/tb_kbd_ps2.sv
// Randomised bench for kbd_ps2: PS/2 frames driven on the pins, FIFO tracked by a queue model.
module tb_kbd_ps2;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 500;
  localparam int HALF    = 6;
`ifdef KBD_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic       iClk = 1'b0;
  logic       iRst = 1'b1;
  logic       iPs2Clk = 1'b1;
  logic       iPs2Dat = 1'b1;
  logic       iAck = 1'b0;
  logic       oIrq, oOvf;
  logic [7:0] oData;

  kbd_ps2 #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .iClk(iClk), .iRst(iRst), .iPs2Clk(iPs2Clk), .iPs2Dat(iPs2Dat),
    .iAck(iAck), .oIrq(oIrq), .oData(oData), .oOvf(oOvf)
  );

  always #5 iClk = ~iClk;

  int nTests = 0;
  int nFails = 0;
  logic [7:0] q[$];
  logic ovfM = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nTests++;
    if (got !== exp) begin
      nFails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge iClk);
    #1;
  endtask

  task automatic checkAll(input string tag);
    check({tag, ".irq"},  oIrq,  q.size() != 0);
    check({tag, ".data"}, oData, (q.size() != 0) ? q[0] : 8'h00);
    check({tag, ".ovf"},  oOvf,  ovfM);
  endtask

  task automatic sendBit(input logic b);
    iPs2Dat = b;
    tick(HALF);
    iPs2Clk = 1'b0;
    tick(HALF);
    iPs2Clk = 1'b1;
  endtask

  task automatic doReset();
    iPs2Clk = 1'b1;
    iPs2Dat = 1'b1;
    iRst = 1'b1;
    tick(2);
    iRst = 1'b0;
    q.delete();
    ovfM = 1'b0;
    tick(3);
  endtask

  task automatic doAck(input string tag);
    iAck = 1'b1;
    tick(1);
    iAck = 1'b0;
    if (q.size() != 0) void'(q.pop_front());
    ovfM = 1'b0;
    checkAll(tag);
  endtask

  // Full frame; the stop-bit edge is checked one cycle before and right after it is processed.
  task automatic sendFrame(input logic [7:0] d, input bit parBad, input bit stopVal,
                           input bit ackAtStop);
    logic p;
    bit valid, wasEmpty, wasFull, setO;
    p = (~^d) ^ parBad;
    sendBit(1'b0);
    for (int i = 0; i < 8; i++) sendBit(d[i]);
    sendBit(p);
    iPs2Dat = stopVal;
    tick(HALF);
    iPs2Clk = 1'b0;
    tick(2);
    checkAll("prestop");
    iAck = ackAtStop;
    tick(1);
    iAck = 1'b0;
    valid    = stopVal && (!PAR_EN || !parBad);
    wasEmpty = (q.size() == 0);
    wasFull  = (q.size() == DEPTH);
    setO     = valid && wasFull && !ackAtStop;
    if (valid && !setO) q.push_back(d);
    if (ackAtStop && !wasEmpty) void'(q.pop_front());
    if (setO) ovfM = 1'b1;
    else if (ackAtStop) ovfM = 1'b0;
    checkAll("stop");
    tick(HALF - 3);
    iPs2Clk = 1'b1;
    iPs2Dat = 1'b1;
    tick(HALF);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    doReset();
    checkAll("reset");

    sendFrame(8'h1C, 1'b0, 1'b1, 1'b0);
    check("single.data", oData, 8'h1C);
    doAck("single.ack");
    check("single.empty", oData, 8'h00);

    sendFrame(8'h1C, 1'b1, 1'b1, 1'b0);
    checkAll("badpar");
    if (q.size() != 0) doAck("badpar.ack");

    doReset();
    for (int i = 1; i <= 5; i++) sendFrame(8'(i), 1'b0, 1'b1, 1'b0);
    check("ovf.set", oOvf, 1'b1);
    for (int i = 0; i < 4; i++) doAck("ovf.drain");
    check("ovf.irq", oIrq, 1'b0);

    doReset();
    for (int i = 1; i <= 4; i++) sendFrame(8'(i), 1'b0, 1'b1, 1'b0);
    sendFrame(8'h05, 1'b0, 1'b1, 1'b1);
    check("simul.ovf", oOvf, 1'b0);
    check("simul.head", oData, 8'h02);
    for (int i = 0; i < 4; i++) doAck("simul.drain");

    doReset();
    sendBit(1'b0);
    sendBit(1'b0);
    sendBit(1'b1);
    sendBit(1'b1);
    tick(TIMEOUT + 10);
    sendFrame(8'hAA, 1'b0, 1'b1, 1'b0);
    check("timeout.data", oData, 8'hAA);
    doAck("timeout.ack");

    doReset();
    sendFrame(8'h55, 1'b0, 1'b1, 1'b0);
    sendBit(1'b0);
    for (int i = 0; i < 4; i++) sendBit(1'b1);
    iRst = 1'b1;
    tick(1);
    iRst = 1'b0;
    q.delete();
    ovfM = 1'b0;
    checkAll("midrst");
    tick(4);
    sendFrame(8'h3A, 1'b0, 1'b1, 1'b0);
    check("midrst.data", oData, 8'h3A);

    doReset();
    repeat (60) begin
      if ($urandom_range(0, 9) < 3) begin
        doAck("rand.ack");
      end else begin
        sendFrame(8'($urandom_range(0, 255)), $urandom_range(0, 3) == 0,
                  $urandom_range(0, 7) != 0, $urandom_range(0, 5) == 0);
      end
      tick($urandom_range(0, 20));
      checkAll("rand");
    end

    $display("[TB] %0d tests run, %0d failed", nTests, nFails);
    $finish;
  end

endmodule
